shift_reg_ctrl: RTL

Sequencer for the 4-bit MUX-based shifting register datapath. It accepts one command at a time over a valid/ready handshake (parallel load, shift left, shift right, rotate right, with a step count). It then drives the MUX select and low-active MUX enable lines, and strobes the register capture enable once per step. Between strobes it waits a programmable settle interval so that MUX outputs are stable before capture.

---
 rtl/shift_ctrl_pkg.sv | 40 ++++
 rtl/shift_reg_ctrl_settle_timer.sv | 32 +++
 rtl/shift_reg_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift-register sequencer.
//   op_e    : command op codes seen on cmd_op
//   sel_e   : datapath MUX select codes driven on mux_sel
//   state_e : sequencer FSM states
//   op_to_sel() maps a command op onto the MUX leg that performs it.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_ROTR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_LOAD  = 2'b01,
        SEL_LEFT  = 2'b10,
        SEL_RIGHT = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETTLE = 2'b01,
        S_STROBE = 2'b10,
        S_DONE   = 2'b11
    } state_e;

    // Rotate-right uses the right-shift leg; rot_en feeds Q[0] back in.
    function automatic logic [1:0] op_to_sel(input logic [1:0] op);
        logic [1:0] sel;
        case (op)
            OP_LOAD: sel = SEL_LOAD;
            OP_SHL:  sel = SEL_LEFT;
            default: sel = SEL_RIGHT;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/shift_reg_ctrl_settle_timer.sv
// settle_timer: loadable down-counter that times the MUX settle interval.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : load the counter; the settle interval begins next cycle
//   expired    : high in the last cycle of the interval
// The interval is SETTLE cycles long starting the cycle after start.
// With SETTLE=0 there is no interval and expired simply follows start.
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic expired
);

    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TW-1:0] RELOAD = TW'((SETTLE > 0) ? SETTLE - 1 : 0);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= RELOAD;
        else if (cnt != '0)
            cnt <= cnt - TW'(1);
    end

    assign expired = (SETTLE == 0) ? start : (cnt == '0);

endmodule

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: sequencer for the 4-bit MUX-based shift register.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake, ready only while idle
//   cmd_op, cmd_cnt     : op (LOAD/SHL/SHR/ROTR) and step count
//   mux_sel, mux_enb    : datapath MUX select, active-low MUX enable
//   rot_en              : routes Q[0] to serial-in (ROTR)
//   reg_ce              : one-cycle capture strobe per step
//   busy, done          : command in progress / completion pulse
//   steps_left          : strobes remaining in current command
// All outputs are registered; they are loaded from the next-state value so
// they line up with the state they describe.
module shift_reg_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [1:0]       mux_sel,
    output logic             mux_enb,
    output logic             rot_en,
    output logic             reg_ce,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    // After acceptance or a non-final strobe the FSM waits out the settle
    // interval, or goes straight to the strobe when there is none.
    localparam state_e S_GAP = (SETTLE > 0) ? S_SETTLE : S_STROBE;

    state_e           state, state_n;
    logic             accept;
    logic [CNT_W-1:0] eff_cnt;
    logic [CNT_W-1:0] steps_dec;
    logic             tmr_start;
    logic             tmr_expired;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (tmr_start),
        .expired (tmr_expired)
    );

    always_comb begin
        state_n   = state;
        accept    = cmd_valid && cmd_ready;
        eff_cnt   = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_cnt;
        steps_dec = steps_left - CNT_W'(1);
        case (state)
            S_IDLE:   if (accept) state_n = (eff_cnt == '0) ? S_DONE : S_GAP;
            S_SETTLE: if (tmr_expired) state_n = S_STROBE;
            S_STROBE: state_n = (steps_dec != '0) ? S_GAP : S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        tmr_start = (state_n == S_SETTLE) && (state != S_SETTLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            reg_ce     <= 1'b0;
            mux_sel    <= SEL_HOLD;
            mux_enb    <= 1'b1;
            rot_en     <= 1'b0;
            steps_left <= '0;
        end else begin
            state     <= state_n;
            cmd_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            reg_ce    <= (state_n == S_STROBE);

            // A zero-count command never touches the MUX controls.
            if (accept && eff_cnt != '0) begin
                mux_sel    <= op_to_sel(cmd_op);
                mux_enb    <= 1'b0;
                rot_en     <= (cmd_op == OP_ROTR);
                steps_left <= eff_cnt;
            end

            if (state == S_STROBE)
                steps_left <= steps_dec;

            // Release the MUX as DONE begins, one cycle after the last strobe.
            if (state_n == S_DONE) begin
                mux_sel <= SEL_HOLD;
                mux_enb <= 1'b1;
                rot_en  <= 1'b0;
            end
        end
    end

endmodule
